// File: rtl/l2_norm_vec.sv
// Streaming L2-norm engine: accumulates squared samples per vector, then extracts the
// floor square root with a restoring one-bit-per-cycle unit and holds it on a valid/ready output.
module l2_norm_vec #(
    parameter  int DATA_W  = 8,
    parameter  int VEC_LEN = 16,
    parameter  int SIGNED  = 0,
    localparam int ACC_W   = 2*DATA_W + $clog2(VEC_LEN),
    localparam int ROOT_W  = (ACC_W + 1) / 2,
    localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic [ROOT_W-1:0] o_out_norm,
    output logic [CNT_W-1:0]  o_out_count,
    output logic              o_out_valid,
    input  logic              i_out_ready
);

    localparam int RAD_W = 2*ROOT_W;
    localparam int REM_W = ROOT_W + 1;
    localparam int IT_W  = $clog2(ROOT_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SQRT, S_HOLD} state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [RAD_W-1:0]  r_rad;
    logic [REM_W-1:0]  r_rem;
    logic [ROOT_W-1:0] r_root;
    logic [IT_W-1:0]   r_iter;

    logic signed [DATA_W:0]  w_ext;
    logic [2*DATA_W-1:0]     w_sq;
    logic [ACC_W-1:0]        w_acc_sum;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_close;
    logic [REM_W+1:0]        w_rem_shift;
    logic [REM_W+1:0]        w_trial;
    logic                    w_fits;
    logic [REM_W-1:0]        w_rem_next;
    logic [ROOT_W-1:0]       w_root_next;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_ext = {i_in_data[DATA_W-1], i_in_data};
        end else begin : g_unsigned
            assign w_ext = {1'b0, i_in_data};
        end
    endgenerate

    // The true square is non-negative and below 2^(2*DATA_W), so the low product bits are exact.
    assign w_sq      = (2*DATA_W)'(w_ext) * (2*DATA_W)'(w_ext);
    assign w_acc_sum = r_acc + ACC_W'(w_sq);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_close   = i_in_last || (w_cnt_inc == CNT_W'(VEC_LEN));

    // One restoring step: bring down two radicand bits, try subtracting (4*root + 1).
    assign w_rem_shift = {r_rem, r_rad[RAD_W-1 -: 2]};
    assign w_trial     = {1'b0, r_root, 2'b01};
    assign w_fits      = (w_rem_shift >= w_trial);
    assign w_rem_next  = w_fits ? REM_W'(w_rem_shift - w_trial) : REM_W'(w_rem_shift);
    assign w_root_next = ROOT_W'({r_root, w_fits});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_iter      <= '0;
            o_in_ready  <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_norm  <= '0;
            o_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_ACCUM;
                    o_in_ready <= 1'b1;
                end
                S_ACCUM: begin
                    if (i_in_valid && o_in_ready) begin
                        r_acc <= w_acc_sum;
                        r_cnt <= w_cnt_inc;
                        if (w_close) begin
                            r_state    <= S_SQRT;
                            o_in_ready <= 1'b0;
                            r_rad      <= RAD_W'(w_acc_sum);
                            r_rem      <= '0;
                            r_root     <= '0;
                            r_iter     <= '0;
                        end
                    end
                end
                S_SQRT: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_iter <= r_iter + IT_W'(1);
                    if (r_iter == IT_W'(ROOT_W - 1)) begin
                        r_state     <= S_HOLD;
                        o_out_norm  <= w_root_next;
                        o_out_count <= r_cnt;
                        o_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_state     <= S_ACCUM;
                        o_out_valid <= 1'b0;
                        o_in_ready  <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_norm_vec.sv
// Bench for l2_norm_vec: unsigned and signed instances share one input stream and are
// compared against a sum-of-squares / integer-sqrt model.
`timescale 1ns/1ps
module tb_l2_norm_vec;

    localparam int DATA_W  = 8;
    localparam int VEC_LEN = 16;
    localparam int ROOT_W  = 10;
    localparam int CNT_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              out_ready;

    logic              u_in_ready, s_in_ready;
    logic [ROOT_W-1:0] u_out_norm, s_out_norm;
    logic [CNT_W-1:0]  u_out_count, s_out_count;
    logic              u_out_valid, s_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] vec [VEC_LEN];
    int                cur_len;

    always #5 clk = ~clk;

    l2_norm_vec #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .SIGNED(0)) u_dut_u (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .i_in_last(in_last), .o_in_ready(u_in_ready), .o_out_norm(u_out_norm),
        .o_out_count(u_out_count), .o_out_valid(u_out_valid), .i_out_ready(out_ready)
    );

    l2_norm_vec #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .SIGNED(1)) u_dut_s (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .i_in_last(in_last), .o_in_ready(s_in_ready), .o_out_norm(s_out_norm),
        .o_out_count(s_out_count), .o_out_valid(s_out_valid), .i_out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint isqrt(input longint s);
        longint r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic longint model_norm(input bit is_signed);
        longint s = 0;
        longint v;
        for (int i = 0; i < cur_len; i++) begin
            v = is_signed ? longint'($signed(vec[i])) : longint'(vec[i]);
            s += v * v;
        end
        return isqrt(s);
    endfunction

    task automatic feed(input bit use_last);
        int w;
        for (int i = 0; i < cur_len; i++) begin
            in_data  = vec[i];
            in_valid = 1'b1;
            in_last  = use_last && (i == cur_len - 1);
            w = 0;
            while (!u_in_ready && w < 30) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 30) check("in_ready_wait", u_in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!u_out_valid && waited < 40);
        check("latency", waited, ROOT_W);
        check("in_ready_busy", u_in_ready, 0);
        check("s_out_valid", s_out_valid, 1);
        check("u_norm", u_out_norm, model_norm(1'b0));
        check("s_norm", s_out_norm, model_norm(1'b1));
        check("u_count", u_out_count, cur_len);
        check("s_count", s_out_count, cur_len);
        $display("vector len=%0d u_norm=%0d s_norm=%0d count=%0d", cur_len, u_out_norm, s_out_norm, u_out_count);
    endtask

    task automatic accept(input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", u_out_valid, 0);
        check("ready_rise", u_in_ready, 1);
    endtask

    task automatic fill(input int len, input logic [DATA_W-1:0] v);
        cur_len = len;
        for (int i = 0; i < len; i++) vec[i] = v;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_in_ready", u_in_ready, 0);
        check("rst_out_valid", u_out_valid, 0);
        check("rst_norm", u_out_norm, 0);
        check("rst_count", u_out_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", u_in_ready, 1);

        // [3,4] -> 5
        cur_len = 2; vec[0] = 8'd3; vec[1] = 8'd4;
        feed(1'b1); wait_result(); accept(0);

        // 16 x 255, auto close
        fill(16, 8'd255); feed(1'b0); wait_result(); accept(1);
        check("norm_1020", u_out_norm, 1020);

        // 16 x -128 -> 512 in both modes
        fill(16, 8'h80); feed(1'b0); wait_result(); accept(0);

        // -3, 4 : signed 5, no residue from previous vector
        cur_len = 2; vec[0] = 8'hFD; vec[1] = 8'd4;
        feed(1'b1); wait_result(); accept(0);
        check("s_norm_5", s_out_norm, 5);

        // floor and single-sample cases; in_last with in_valid low first
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        check("last_no_valid", u_in_ready, 1);
        cur_len = 2; vec[0] = 8'd1; vec[1] = 8'd1;
        feed(1'b1); wait_result(); accept(0);
        fill(1, 8'd0); feed(1'b1); wait_result(); accept(0);
        fill(1, 8'd7); feed(1'b1); wait_result(); accept(2);

        // in_last on the 16th sample
        fill(16, 8'd255); feed(1'b1); wait_result(); accept(0);

        // back-pressure with a pending sample of 9
        cur_len = 2; vec[0] = 8'd3; vec[1] = 8'd4;
        feed(1'b1); wait_result();
        in_data = 8'd9; in_valid = 1'b1; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", u_out_valid, 1);
            check("bp_norm", u_out_norm, 5);
            check("bp_count", u_out_count, 2);
            check("bp_in_ready", u_in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_xfer_valid", u_out_valid, 0);
        check("bp_xfer_ready", u_in_ready, 1);
        @(posedge clk); #1;
        check("bp_sample_taken", u_in_ready, 0);
        in_valid = 1'b0; in_last = 1'b0;
        fill(1, 8'd9); wait_result(); accept(0);

        // asynchronous reset mid-SQRT
        cur_len = 2; vec[0] = 8'd5; vec[1] = 8'd5;
        feed(1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_valid", u_out_valid, 0);
        check("arst_ready", u_in_ready, 0);
        check("arst_norm", u_out_norm, 0);
        check("arst_count", u_out_count, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ready_back", u_in_ready, 1);
        cur_len = 2; vec[0] = 8'd6; vec[1] = 8'd8;
        feed(1'b1); wait_result(); accept(0);
        check("norm_10", u_out_norm, 10);

        // randomized vectors
        for (int t = 0; t < 20; t++) begin
            bit use_last;
            cur_len = $urandom_range(1, VEC_LEN);
            for (int i = 0; i < cur_len; i++) vec[i] = DATA_W'($urandom);
            use_last = (cur_len < VEC_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            feed(use_last); wait_result(); accept($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_norm_vec.md
# l2_norm_vec

Parametrised streaming L2-norm engine. It accepts a vector of DATA_W-bit samples over a valid/ready handshake and accumulates their squares. It then computes the floor integer square root with an iterative one-bit-per-cycle unit and presents the norm on a valid/ready output. It supersedes the fixed 8-bit, free-running accumulator with these additions: per-vector framing (fixed length or early `in_last`), automatic accumulator clear, signed input mode, back-pressure, and a multiplier-free sequential square root.

## Interface
- DATA_W, 8: sample width in bits.
- VEC_LEN, 16: maximum samples per vector; the vector closes automatically on sample VEC_LEN. Must be ≥1.
- SIGNED, 0: 1 = samples are two's complement; 0 = unsigned.
- ACC_W (localparam): 2*DATA_W + $clog2(VEC_LEN). Accumulator width; overflow is impossible by construction.
- ROOT_W (localparam): (ACC_W+1)/2. Root width, which is also the number of sqrt iterations.
- CNT_W (localparam): $clog2(VEC_LEN+1).
- clk, input, 1: the single clock; all state changes on rising edge.
- reset, input, 1: asynchronous, active-high.
- in_data, input, DATA_W: sample.
- in_valid, input, 1: sample present.
- in_last, input, 1: sample is the final one of the vector. Qualified by in_valid & in_ready.
- in_ready, output, 1: block can accept a sample.
- out_norm, output, ROOT_W: floor(sqrt(sum of squares)).
- out_count, output, CNT_W: number of samples in the vector just normed.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.

## Operation
- FSM states: IDLE → ACCUM → SQRT → HOLD → ACCUM.
  - Reset forces IDLE. IDLE always moves to ACCUM on the next edge.
- Transfer rules:
  - Input transfer occurs on an edge where in_valid & in_ready are both high.
  - Output transfer occurs on an edge where out_valid & out_ready are both high.
- ACCUM state:
  - in_ready = 1.
  - Each input transfer does acc <= acc + sq and cnt <= cnt + 1.
  - sq = in_data*in_data, computed as an unsigned magnitude square when SIGNED=0 and as a signed square when SIGNED=1 (so -128 squares to 16384).
  - The vector closes on a transfer with in_last=1, or on the transfer that makes cnt == VEC_LEN, whichever comes first. On that edge, go to SQRT.
  - No transfer leaves all state unchanged.
- SQRT state:
  - in_ready = 0.
  - Restoring digit-by-digit square root, MSB first, one root bit per cycle, exactly ROOT_W cycles.
  - Uses shifts, subtracts and compares only; no multiplier and no vendor IP.
  - After the final iteration, load out_norm and out_count and go to HOLD.
- HOLD state:
  - out_valid = 1; out_norm and out_count are held stable.
  - in_ready = 0, so no samples are accepted while a result is pending.
  - On an output transfer: clear acc and cnt to 0, drop out_valid, go to ACCUM.
- Width rules:
  - All arithmetic is unsigned after squaring.
  - out_norm is the exact floor root; there is no rounding.
- Boundary conditions:
  - in_last asserted with in_valid low is ignored.
  - in_last on the VEC_LEN-th sample closes the vector once, with the same result as either condition alone.
  - A single-sample vector (in_last on the first transfer) is legal.
  - An all-zero vector gives out_norm = 0.
  - in_valid held high during SQRT/HOLD is not consumed; the sample must be held by the source until in_ready.
- Reset mid-operation (any state): the partial vector is discarded, any pending result is dropped, and all outputs return to their reset values immediately.

## Timing
- Reset values: in_ready=0, out_valid=0, out_norm=0, out_count=0. Internal acc=0, cnt=0, state=IDLE.
- in_ready rises on the first clk edge after reset deasserts (IDLE→ACCUM).
- Throughput: one sample per cycle in ACCUM.
- Latency: last sample accepted at edge k → out_valid high after edge k+ROOT_W. That is 10 cycles with the default parameters.
- Output timing:
  - out_valid stays high until the transfer edge.
  - in_ready rises on that same edge.
  - The next vector's first sample can be accepted on the following edge.
- Minimum vector period: samples + ROOT_W + 1 cycles when out_ready is tied high.
- All outputs are registered or decoded from state registers only. There are no combinational paths from in_* or out_ready to any output.

## Test plan
- Defaults, unsigned: send 3, then 4 with in_last=1 → after 10 cycles out_norm=5, out_count=2; in_ready=0 until the output transfer.
- Defaults: 16 samples of 255, no in_last → auto-close on the 16th; out_norm=1020, out_count=16; no overflow.
- SIGNED=1: 16 samples of -128 → out_norm=512. Then a vector of -3, 4 (last) → out_norm=5, and the accumulator is confirmed cleared between vectors.
- Floor and edge cases: [1,1,last] → out_norm=1 (floor of √2); [0,last] → out_norm=0, out_count=1; [7,last] → out_norm=7.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises → out_norm and out_count stable, in_ready=0, source in_valid held with data 9 is not consumed. Raise out_ready → the held sample is accepted one edge after the output transfer.
- Async reset asserted between clock edges mid-SQRT → out_valid, in_ready, out_norm and out_count go to 0 before the next edge. After release, [6,8,last] → out_norm=10 with no residue from the aborted vector.
